pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32: width of all address/PC signals.
REQ-002 Parameter INITIAL_PC, default 32'h0000_0000: PC loaded on reset.
REQ-003 Parameter IALIGN, default 32: instruction alignment in bits, 32 or 16; the sequential step is IALIGN/8.
REQ-004 Ports SHALL be:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  suppresses issue of new fetch requests
- trap_valid  in  1  trap redirect request
- trap_target  in  XLEN  trap vector address
- redirect_valid  in  1  branch/jump redirect request
- redirect_target  in  XLEN  branch/jump target
- fetch_req  out  1  fetch request valid
- fetch_addr  out  XLEN  fetch address, equal to the current PC
- fetch_ready  in  1  memory accepts the request this cycle
- fetch_rvalid  in  1  memory returns the fetched word this cycle
- out_valid  out  1  one-cycle pulse: instruction for out_pc delivered downstream
- out_pc  out  XLEN  PC of the delivered instruction
- pc  out  XLEN  current architectural fetch PC

Function
REQ-005 The state machine SHALL have states BOOT, ISSUE and WAIT, and at most one fetch outstanding.
REQ-006 BOOT: fetch_req=0 for exactly one cycle after reset deasserts, then go to ISSUE.
REQ-007 ISSUE: fetch_req = !stall.
- If fetch_req and fetch_ready are both high, go to WAIT.
- Otherwise stay in ISSUE; pc is unchanged.
REQ-008 WAIT: fetch_req=0. On fetch_rvalid with no kill pending:
- out_valid=1 and out_pc=pc, combinationally in the same cycle;
- pc <= pc + IALIGN/8;
- go to ISSUE.
REQ-009 PC increment SHALL wrap modulo 2^XLEN; for example, XLEN'hFFFF_FFFC + 4 gives 0.
REQ-010 Redirect priority SHALL be trap_valid over redirect_valid. The selected target SHALL have its low log2(IALIGN/8) bits forced to zero.
REQ-011 A redirect in BOOT or ISSUE SHALL load pc with the target at the next edge.
- The state is unchanged; BOOT still goes to ISSUE.
- Any fetch_req/fetch_ready acceptance in that same cycle is cancelled: the state stays ISSUE.
REQ-012 A redirect in WAIT without fetch_rvalid SHALL:
- load pc with the target;
- set an internal kill flag;
- keep the state in WAIT.
REQ-013 In WAIT with kill set, fetch_rvalid SHALL:
- produce no out_valid;
- clear kill;
- go to ISSUE; pc is not incremented.
REQ-014 A redirect coinciding with fetch_rvalid in WAIT SHALL:
- suppress out_valid;
- load pc with the target;
- leave kill clear;
- go to ISSUE.
REQ-015 A redirect arriving while kill is already set SHALL overwrite pc with the newest target; kill stays set.
REQ-016 stall SHALL NOT affect WAIT, response delivery, or redirect capture.
REQ-017 fetch_addr SHALL always equal pc.
REQ-018 out_valid SHALL never be high outside WAIT.

Reset
REQ-019 reset SHALL act asynchronously and set:
- pc = INITIAL_PC (with low alignment bits forced to zero);
- state = BOOT, kill = 0;
- fetch_req = 0, out_valid = 0, out_pc = 0.
REQ-020 Reset mid-WAIT SHALL abandon the outstanding fetch. A fetch_rvalid arriving in the first cycles after reset (during BOOT or ISSUE) SHALL be ignored.
REQ-021 All registers SHALL also take their reset values at time zero via initial assignment, for FPGA bring-up.

Structure
REQ-022 The state enumeration and the default INITIAL_PC constant SHALL live in the shared core config/constants package. The step size is derived locally from IALIGN.
REQ-023 One sub-module, pc_redirect_select, SHALL be used. It is combinational and covers trap/branch priority plus alignment masking. Everything else stays in pc_sequencer.

Verification
REQ-024 Reset release, fetch_ready=1 and rvalid 2 cycles after each accept (XLEN=32, INITIAL_PC=0) -> fetch_addr 0, 4, 8; out_pc 0, 4, 8 with one out_valid each.
REQ-025 redirect_valid=1 with target 32'h100 in WAIT, then rvalid 3 cycles later -> no out_valid for the old word; next fetch_addr is 32'h100.
REQ-026 trap_valid (target 32'h200) and redirect_valid (target 32'h300) in the same cycle -> pc becomes 32'h200.
REQ-027 IALIGN=16, redirect target 32'h103 -> pc 32'h102, then 32'h104 after a delivery; XLEN=32 with pc 32'hFFFF_FFFC and IALIGN=32 -> after delivery pc is 0.
REQ-028 stall=1 for 5 cycles in ISSUE -> fetch_req stays 0 and pc is stable; reset asserted mid-WAIT followed by a stray rvalid -> no out_valid, pc returns to INITIAL_PC.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared core constants for the PC sequencer.
//   pc_state_t         : fetch sequencer state encoding
//   DEFAULT_INITIAL_PC : reset PC used when the instantiator does not override it
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEFAULT_INITIAL_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_select.sv
// Redirect source selection: trap wins over branch/jump, and the chosen target
// is forced onto the instruction alignment grid.
// Ports:
//   trap_valid/trap_target         : trap vector request
//   redirect_valid/redirect_target : branch/jump request
//   redir_valid                    : either request present
//   redir_target                   : selected, aligned target
module pc_redirect_select
  import pc_sequencer_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ALIGN_BITS = 2
) (
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_target
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'((1 << ALIGN_BITS) - 1);

  logic [XLEN-1:0] raw_target;

  assign redir_valid  = trap_valid | redirect_valid;
  assign raw_target   = trap_valid ? trap_target : redirect_target;
  assign redir_target = raw_target & ~LOW_MASK;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch PC sequencer with a single outstanding fetch.
// Ports:
//   clock, reset                    : rising-edge clock, async active-high reset
//   stall                           : holds off new fetch requests
//   trap_valid/trap_target          : trap redirect (highest priority)
//   redirect_valid/redirect_target  : branch/jump redirect
//   fetch_req/fetch_addr            : fetch request and its address (= pc)
//   fetch_ready                     : memory accepts the request this cycle
//   fetch_rvalid                    : memory returns the fetched word
//   out_valid/out_pc                : delivery pulse and PC of delivered word
//   pc                              : current architectural fetch PC
//
// state | meaning
// BOOT  | one idle cycle after reset release
// ISSUE | presenting fetch_req for pc (unless stalled)
// WAIT  | one fetch outstanding, waiting for fetch_rvalid
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] INITIAL_PC = XLEN'(DEFAULT_INITIAL_PC),
  parameter int              IALIGN     = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            fetch_req,
  output logic [XLEN-1:0] fetch_addr,
  input  logic            fetch_ready,
  input  logic            fetch_rvalid,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] pc
);

  localparam int              ALIGN_BITS = (IALIGN == 16) ? 1 : 2;
  localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN / 8);
  localparam logic [XLEN-1:0] LOW_MASK   = XLEN'((1 << ALIGN_BITS) - 1);
  localparam logic [XLEN-1:0] RESET_PC   = INITIAL_PC & ~LOW_MASK;

  // Declaration initialisers give FPGA bring-up the same values as reset.
  pc_state_t       state = BOOT;
  logic            kill  = 1'b0;
  logic [XLEN-1:0] pc_q  = RESET_PC;

  logic            redir_valid;
  logic [XLEN-1:0] redir_target;
  logic            accept;

  pc_redirect_select #(
    .XLEN       (XLEN),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_redirect_select (
    .trap_valid      (trap_valid),
    .trap_target     (trap_target),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .redir_valid     (redir_valid),
    .redir_target    (redir_target)
  );

  assign fetch_req  = (state == ISSUE) && !stall;
  assign accept     = fetch_req && fetch_ready;
  assign fetch_addr = pc_q;
  assign pc         = pc_q;

  // A response is only delivered if it still belongs to the current pc:
  // neither killed by an earlier redirect nor overtaken by one this cycle.
  assign out_valid = (state == WAIT) && fetch_rvalid && !kill && !redir_valid;
  assign out_pc    = out_valid ? pc_q : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      kill  <= 1'b0;
      pc_q  <= RESET_PC;
    end else begin
      case (state)
        BOOT: begin
          if (redir_valid) pc_q <= redir_target;
          state <= ISSUE;
        end
        ISSUE: begin
          // A redirect cancels any acceptance seen in the same cycle.
          if (redir_valid) pc_q <= redir_target;
          else if (accept) state <= WAIT;
        end
        WAIT: begin
          if (fetch_rvalid) begin
            state <= ISSUE;
            kill  <= 1'b0;
            if (redir_valid)  pc_q <= redir_target;
            else if (!kill)   pc_q <= pc_q + STEP;
          end else if (redir_valid) begin
            // Fetch still in flight for the old pc: drop its response later.
            pc_q <= redir_target;
            kill <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Expected delivered PCs go into a queue when a
// fetch is issued; a negedge monitor pops and compares on every out_valid.
module tb_pc_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  // Instance A: XLEN=32, IALIGN=32, INITIAL_PC=0
  logic        stall = 0, trap_valid = 0, redirect_valid = 0;
  logic [31:0] trap_target = 0, redirect_target = 0;
  logic        fetch_ready = 0, fetch_rvalid = 0;
  logic        fetch_req, out_valid;
  logic [31:0] fetch_addr, out_pc, pc;

  // Instance B: IALIGN=16
  logic        stall_b = 1, trap_valid_b = 0, redirect_valid_b = 0;
  logic [31:0] trap_target_b = 0, redirect_target_b = 0;
  logic        fetch_ready_b = 0, fetch_rvalid_b = 0;
  logic        fetch_req_b, out_valid_b;
  logic [31:0] fetch_addr_b, out_pc_b, pc_b;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_b_q[$];

  always #5 clock = ~clock;

  pc_sequencer #(.XLEN(32), .INITIAL_PC(32'h0), .IALIGN(32)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_rvalid(fetch_rvalid),
    .out_valid(out_valid), .out_pc(out_pc), .pc(pc)
  );

  pc_sequencer #(.XLEN(32), .INITIAL_PC(32'h0), .IALIGN(16)) dut_b (
    .clock(clock), .reset(reset), .stall(stall_b),
    .trap_valid(trap_valid_b), .trap_target(trap_target_b),
    .redirect_valid(redirect_valid_b), .redirect_target(redirect_target_b),
    .fetch_req(fetch_req_b), .fetch_addr(fetch_addr_b),
    .fetch_ready(fetch_ready_b), .fetch_rvalid(fetch_rvalid_b),
    .out_valid(out_valid_b), .out_pc(out_pc_b), .pc(pc_b)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one fetch on instance A and return its word 'gap' cycles after accept.
  task automatic do_fetch(input logic [31:0] addr, input int gap);
    fetch_ready = 1;
    #1;
    check("issue_req", {31'b0, fetch_req}, 32'd1);
    check("issue_addr", fetch_addr, addr);
    exp_q.push_back(addr);
    tick();
    fetch_ready = 0;
    check("wait_req", {31'b0, fetch_req}, 32'd0);
    repeat (gap - 1) tick();
    fetch_rvalid = 1;
    tick();
    fetch_rvalid = 0;
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out_valid: got out_pc %h expected no delivery", out_pc);
      end else begin
        check("out_pc", out_pc, exp_q.pop_front());
      end
    end
    if (out_valid_b) begin
      if (exp_b_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out_valid_b: got out_pc %h expected no delivery", out_pc_b);
      end else begin
        check("out_pc_b", out_pc_b, exp_b_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'b0, fetch_req}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    tick(); tick();
    reset = 0;
    #1;
    check("boot_req", {31'b0, fetch_req}, 32'd0);
    tick();

    // Sequential fetches 0, 4, 8
    do_fetch(32'h0, 2);
    do_fetch(32'h4, 2);
    do_fetch(32'h8, 2);
    check("seq_pc", pc, 32'hC);

    // Redirect while waiting: old word killed
    fetch_ready = 1; tick(); fetch_ready = 0;
    redirect_valid = 1; redirect_target = 32'h100; tick(); redirect_valid = 0;
    check("kill_pc", pc, 32'h100);
    check("kill_wait_req", {31'b0, fetch_req}, 32'd0);
    tick(); tick();
    fetch_rvalid = 1; #1;
    check("kill_no_out", {31'b0, out_valid}, 32'd0);
    tick(); fetch_rvalid = 0;
    check("kill_next_addr", fetch_addr, 32'h100);
    check("kill_next_req", {31'b0, fetch_req}, 32'd1);

    // Trap over redirect; acceptance in the same cycle cancelled
    fetch_ready = 1;
    trap_valid = 1; trap_target = 32'h200;
    redirect_valid = 1; redirect_target = 32'h300;
    tick();
    trap_valid = 0; redirect_valid = 0; fetch_ready = 0;
    check("trap_prio_pc", pc, 32'h200);
    check("trap_cancel_req", {31'b0, fetch_req}, 32'd1);

    // Redirect coinciding with rvalid
    fetch_ready = 1; tick(); fetch_ready = 0;
    fetch_rvalid = 1; redirect_valid = 1; redirect_target = 32'h400; #1;
    check("coinc_no_out", {31'b0, out_valid}, 32'd0);
    tick(); fetch_rvalid = 0; redirect_valid = 0;
    check("coinc_pc", pc, 32'h400);
    check("coinc_req", {31'b0, fetch_req}, 32'd1);
    do_fetch(32'h400, 2);
    check("coinc_kill_clear_pc", pc, 32'h404);

    // Two redirects while killed: newest target wins
    fetch_ready = 1; tick(); fetch_ready = 0;
    redirect_valid = 1; redirect_target = 32'h500; tick();
    redirect_target = 32'h600; tick(); redirect_valid = 0;
    check("rekill_pc", pc, 32'h600);
    fetch_rvalid = 1; #1;
    check("rekill_no_out", {31'b0, out_valid}, 32'd0);
    tick(); fetch_rvalid = 0;
    check("rekill_pc_after", pc, 32'h600);
    check("rekill_req", {31'b0, fetch_req}, 32'd1);

    // Stall does not block delivery in WAIT; stall holds ISSUE for 5 cycles
    fetch_ready = 1; tick(); fetch_ready = 0;
    stall = 1; tick();
    fetch_rvalid = 1; exp_q.push_back(32'h600); tick(); fetch_rvalid = 0;
    check("stall_wait_pc", pc, 32'h604);
    fetch_ready = 1;
    for (int i = 0; i < 5; i++) begin
      check("stall_req", {31'b0, fetch_req}, 32'd0);
      check("stall_pc", pc, 32'h604);
      tick();
    end
    fetch_ready = 0; stall = 0; #1;
    check("unstall_req", {31'b0, fetch_req}, 32'd1);

    // Alignment mask and wrap
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFE; tick(); redirect_valid = 0;
    check("align32_pc", pc, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 2);
    check("wrap_pc", pc, 32'h0);

    // Reset mid-WAIT with stray rvalid afterwards
    redirect_valid = 1; redirect_target = 32'h700; tick(); redirect_valid = 0;
    fetch_ready = 1; tick(); fetch_ready = 0;
    check("pre_reset_pc", pc, 32'h700);
    reset = 1; #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_req", {31'b0, fetch_req}, 32'd0);
    tick(); reset = 0;
    fetch_rvalid = 1; #1;
    check("stray_boot_out", {31'b0, out_valid}, 32'd0);
    check("stray_boot_req", {31'b0, fetch_req}, 32'd0);
    tick();
    check("stray_issue_out", {31'b0, out_valid}, 32'd0);
    check("stray_issue_req", {31'b0, fetch_req}, 32'd1);
    fetch_rvalid = 0;
    check("stray_pc", pc, 32'h0);

    // IALIGN=16 instance
    tick();
    redirect_valid_b = 1; redirect_target_b = 32'h103; tick(); redirect_valid_b = 0;
    check("align16_pc", pc_b, 32'h102);
    stall_b = 0; fetch_ready_b = 1; #1;
    check("align16_addr", fetch_addr_b, 32'h102);
    exp_b_q.push_back(32'h102);
    tick(); fetch_ready_b = 0;
    tick();
    fetch_rvalid_b = 1; tick(); fetch_rvalid_b = 0;
    check("align16_step_pc", pc_b, 32'h104);

    tick(); tick();
    check("pending_a", exp_q.size(), 32'd0);
    check("pending_b", exp_b_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
